// File: rtl/power_level_ctrl.sv
// power_level_ctrl
//   Power set-point controller: takes decoded command strobes, keeps a
//   saturating power level, drives a PWM output whose duty follows the level
//   at period boundaries, and offers {enabled, level} status reports over a
//   valid/ready handshake.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   valid      in   command strobe (one command per asserted cycle)
//   on, off    in   output-stage enable / disable (off wins)
//   increase   in   level += amount, saturating at LEVEL_MAX
//   decrease   in   level -= amount, clamping at 0
//   send       in   request a status report
//   receive    in   level = min(amount, LEVEL_MAX)
//   amount     in   operand [AMOUNT_WIDTH]
//   enabled    out  registered output-stage enable
//   level      out  registered committed level [AMOUNT_WIDTH]
//   pwm_out    out  registered PWM drive
//   tx_valid   out  report pending
//   tx_data    out  report word {enabled, level} [AMOUNT_WIDTH+1]
//   tx_ready   in   report consumer ready
//   cmd_drop   out  one-cycle pulse when a send is rejected
module power_level_ctrl #(
  parameter int AMOUNT_WIDTH = 8,
  parameter int LEVEL_MAX    = 200,
  parameter int PWM_PERIOD   = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic                    on,
  input  logic                    off,
  input  logic                    increase,
  input  logic                    decrease,
  input  logic                    send,
  input  logic                    receive,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  output logic                    enabled,
  output logic [AMOUNT_WIDTH-1:0] level,
  output logic                    pwm_out,
  output logic                    tx_valid,
  output logic [AMOUNT_WIDTH:0]   tx_data,
  input  logic                    tx_ready,
  output logic                    cmd_drop
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [AMOUNT_WIDTH:0] LMAX_W   = (AMOUNT_WIDTH + 1)'(LEVEL_MAX);
  localparam logic [AMOUNT_WIDTH-1:0] LMAX   = AMOUNT_WIDTH'(LEVEL_MAX);

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  tx_state_t                 r_state;
  logic                      r_enabled;
  logic [AMOUNT_WIDTH-1:0]   r_level;
  logic [AMOUNT_WIDTH-1:0]   r_duty;
  logic [CW-1:0]             r_cnt;
  logic                      r_pwm;
  logic [AMOUNT_WIDTH:0]     r_tx_data;
  logic                      r_cmd_drop;

  logic                      w_enabled_next;
  logic [AMOUNT_WIDTH-1:0]   w_level_next;
  logic [AMOUNT_WIDTH-1:0]   w_duty_next;
  logic [CW-1:0]             w_cnt_next;
  logic [AMOUNT_WIDTH:0]     w_sum;
  logic                      w_send;

  assign w_sum  = {1'b0, r_level} + {1'b0, amount};
  assign w_send = valid & send;

  always_comb begin
    w_enabled_next = r_enabled;
    if (valid) begin
      if (off)
        w_enabled_next = 1'b0;
      else if (on)
        w_enabled_next = 1'b1;
    end
  end

  always_comb begin
    w_level_next = r_level;
    if (valid) begin
      if (receive)
        w_level_next = ({1'b0, amount} > LMAX_W) ? LMAX : amount;
      else if (increase && !decrease)
        w_level_next = (w_sum > LMAX_W) ? LMAX : w_sum[AMOUNT_WIDTH-1:0];
      else if (decrease && !increase)
        w_level_next = (amount <= r_level) ? (r_level - amount) : '0;
    end
  end

  // Duty only follows the level at the period boundary, so a period in
  // flight always completes with the duty it started with.
  assign w_cnt_next  = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
  assign w_duty_next = (r_cnt == CNT_LAST) ? r_level : r_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enabled <= 1'b0;
      r_level   <= '0;
      r_duty    <= '0;
      r_cnt     <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_enabled <= w_enabled_next;
      r_level   <= w_level_next;
      r_duty    <= w_duty_next;
      r_cnt     <= w_cnt_next;
      // Built from next-cycle state so pwm_out lines up with the counter
      // and drops in the same cycle enabled clears.
      r_pwm     <= w_enabled_next & (32'(w_cnt_next) < 32'(w_duty_next));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= TX_IDLE;
      r_tx_data  <= '0;
      r_cmd_drop <= 1'b0;
    end else begin
      r_cmd_drop <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (w_send) begin
            r_state   <= TX_BUSY;
            r_tx_data <= {w_enabled_next, w_level_next};
          end
        end
        TX_BUSY: begin
          if (tx_ready) begin
            // A send coinciding with the completing handshake is taken
            // as the next report rather than dropped.
            if (w_send)
              r_tx_data <= {w_enabled_next, w_level_next};
            else
              r_state   <= TX_IDLE;
          end else if (w_send) begin
            r_cmd_drop <= 1'b1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign enabled  = r_enabled;
  assign level    = r_level;
  assign pwm_out  = r_pwm;
  assign tx_valid = (r_state == TX_BUSY);
  assign tx_data  = r_tx_data;
  assign cmd_drop = r_cmd_drop;

endmodule

// File: tb/tb_power_level_ctrl.sv
module tb_power_level_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, on, off, increase, decrease, send, receive;
  logic [7:0] amount;
  logic       enabled;
  logic [7:0] level;
  logic       pwm_out;
  logic       tx_valid;
  logic [8:0] tx_data;
  logic       tx_ready;
  logic       cmd_drop;

  int errors = 0;
  int checks = 0;

  power_level_ctrl #(.AMOUNT_WIDTH(8), .LEVEL_MAX(200), .PWM_PERIOD(250)) dut (
    .clk(clk), .rst(rst), .valid(valid), .on(on), .off(off),
    .increase(increase), .decrease(decrease), .send(send), .receive(receive),
    .amount(amount), .enabled(enabled), .level(level), .pwm_out(pwm_out),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command cycle; outputs reflect it on return.
  task automatic issue(input logic i_on, input logic i_off, input logic i_inc,
                       input logic i_dec, input logic i_snd, input logic i_rcv,
                       input logic [7:0] i_amt);
    valid = 1'b1; on = i_on; off = i_off; increase = i_inc; decrease = i_dec;
    send = i_snd; receive = i_rcv; amount = i_amt;
    step();
    valid = 1'b0; on = 1'b0; off = 1'b0; increase = 1'b0; decrease = 1'b0;
    send = 1'b0; receive = 1'b0; amount = '0;
  endtask

  // Leaves the bench at the first sample where pwm_out goes 0 -> 1.
  task automatic wait_rise(input string tag);
    bit seen_low = 0;
    bit found = 0;
    for (int i = 0; i < 800 && !found; i++) begin
      if (!pwm_out) seen_low = 1;
      else if (seen_low) found = 1;
      if (!found) step();
    end
    chk(tag, found, 1);
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_out) highs++;
      step();
    end
  endtask

  int h;

  initial begin
    rst = 1'b1; valid = 1'b0; on = 1'b0; off = 1'b0; increase = 1'b0;
    decrease = 1'b0; send = 1'b0; receive = 1'b0; amount = '0; tx_ready = 1'b0;
    repeat (3) step();
    chk("rst_enabled", enabled, 0);
    chk("rst_level", level, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cmd_drop", cmd_drop, 0);
    rst = 1'b0;

    // duty 0 gives a constant-low output
    count_high(260, h);
    chk("duty0_highs", h, 0);

    // valid=0 commands are ignored
    on = 1'b1; receive = 1'b1; amount = 8'd50;
    step();
    on = 1'b0; receive = 1'b0; amount = '0;
    chk("novalid_enabled", enabled, 0);
    chk("novalid_level", level, 0);

    // on + receive 100, then 100 of 250 high per period
    issue(1, 0, 0, 0, 0, 1, 8'd100);
    chk("on_enabled", enabled, 1);
    chk("rcv_level", level, 100);
    wait_rise("rise100");
    count_high(250, h);
    chk("period100_highs", h, 100);

    // mid-period change 100 -> 40: current period keeps 100
    repeat (10) step();
    issue(0, 0, 0, 0, 0, 1, 8'd40);
    chk("rcv40_level", level, 40);
    count_high(239, h);
    chk("cur_period_highs", h, 89);
    count_high(250, h);
    chk("next_period_highs", h, 40);

    // saturation and clamping
    issue(0, 0, 0, 0, 0, 1, 8'd180);
    chk("rcv180", level, 180);
    issue(0, 0, 1, 0, 0, 0, 8'd50);
    chk("inc_sat", level, 200);
    issue(0, 0, 1, 1, 0, 0, 8'd7);
    chk("incdec_hold", level, 200);
    issue(0, 0, 0, 1, 0, 0, 8'd50);
    chk("dec50", level, 150);
    issue(0, 0, 0, 1, 0, 0, 8'd150);
    chk("dec_equal", level, 0);
    issue(0, 0, 0, 1, 0, 0, 8'd255);
    chk("dec_clamp", level, 0);
    issue(0, 0, 0, 0, 0, 1, 8'd255);
    chk("rcv_sat", level, 200);
    issue(0, 0, 1, 1, 0, 1, 8'd100);
    chk("rcv_priority", level, 100);

    // pending report with tx_ready low; second send dropped
    issue(0, 0, 0, 0, 1, 0, 8'd0);
    chk("tx_valid_set", tx_valid, 1);
    chk("tx_data_snap", tx_data, 9'h164);
    step();
    step();
    chk("tx_data_stable", tx_data, 9'h164);
    issue(0, 0, 0, 0, 1, 1, 8'd77);
    chk("drop_pulse", cmd_drop, 1);
    chk("drop_level_exec", level, 77);
    chk("drop_tx_data", tx_data, 9'h164);
    step();
    chk("drop_single", cmd_drop, 0);
    chk("drop_tx_valid", tx_valid, 1);
    step();
    chk("tx_data_stable2", tx_data, 9'h164);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx_done", tx_valid, 0);

    // send coinciding with handshake completion is accepted
    issue(0, 0, 0, 0, 1, 0, 8'd0);
    chk("tx2_data", tx_data, 9'h14D);
    tx_ready = 1'b1;
    issue(0, 0, 1, 0, 1, 0, 8'd3);
    chk("tx3_valid", tx_valid, 1);
    chk("tx3_data", tx_data, 9'h150);
    chk("tx3_nodrop", cmd_drop, 0);
    step();
    tx_ready = 1'b0;
    chk("tx3_done", tx_valid, 0);

    // off mid-high-phase drops pwm next cycle
    wait_rise("rise80");
    repeat (5) step();
    chk("pwm_high_before_off", pwm_out, 1);
    issue(0, 1, 0, 0, 0, 0, 8'd0);
    chk("off_pwm", pwm_out, 0);
    chk("off_enabled", enabled, 0);
    issue(1, 0, 0, 0, 0, 0, 8'd0);
    chk("on_again", enabled, 1);
    issue(1, 1, 0, 0, 1, 0, 8'd0);
    chk("onoff_enabled", enabled, 0);
    chk("onoff_pwm", pwm_out, 0);
    chk("off_snapshot", tx_data, 9'h050);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;

    // reset mid-report
    issue(1, 0, 0, 0, 0, 1, 8'd150);
    issue(0, 0, 0, 0, 1, 0, 8'd0);
    chk("pre_rst_tx_valid", tx_valid, 1);
    chk("pre_rst_level", level, 150);
    rst = 1'b1;
    issue(1, 0, 0, 0, 1, 1, 8'd20);
    chk("rst2_enabled", enabled, 0);
    chk("rst2_level", level, 0);
    chk("rst2_pwm", pwm_out, 0);
    chk("rst2_tx_valid", tx_valid, 0);
    chk("rst2_tx_data", tx_data, 0);
    chk("rst2_cmd_drop", cmd_drop, 0);
    rst = 1'b0;
    step();
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
